hdmi_tx_align: RTL and testbench

HDMI_TX_ALIGN -- requirements
Module: hdmi_tx_align

---
 rtl/hdmi_tx_align.sv | 119 +++++++++++
 tb/tb_hdmi_tx_align.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_align.sv
// Output stage behind a 5x5 median filter: delays the raw timing and centre pixel to the
// filter's output tap, measures the active area and substitutes border pixels.
module hdmi_tx_align #(
    parameter int LATENCY     = 8,
    parameter int BORDER_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic        rx_hs,
    input  logic        rx_vs,
    input  logic [23:0] center_pixel,
    input  logic [7:0]  filt_red,
    input  logic [7:0]  filt_green,
    input  logic [7:0]  filt_blue,
    output logic [7:0]  tx_red,
    output logic [7:0]  tx_green,
    output logic [7:0]  tx_blue,
    output logic        tx_dv,
    output logic        tx_hs,
    output logic        tx_vs,
    output logic [11:0] width,
    output logic [11:0] height
);
    localparam int LW = 27;

    // dv only qualifies a pixel; there is no backpressure, so the line shifts every clock.
    logic [LW-1:0] line_q [LATENCY];
    logic          d_dv;
    logic          d_hs;
    logic          d_vs;
    logic [23:0]   d_pix;
    logic          prev_hs;
    logic          prev_vs;
    logic [11:0]   col;
    logic [11:0]   row;
    logic          hs_rise;
    logic          vs_rise;
    logic          border;
    logic [23:0]   pix_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= {rx_dv, rx_hs, rx_vs, center_pixel};
            for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign {d_dv, d_hs, d_vs, d_pix} = line_q[LATENCY-1];
    assign hs_rise = d_hs && !prev_hs;
    assign vs_rise = d_vs && !prev_vs;

    // Right/bottom tests stay off until a plausible size has been measured.
    always_comb begin
        border = 1'b0;
        if (col < 12'd2 || row < 12'd2)
            border = 1'b1;
        if (width >= 12'd5 && col >= width - 12'd2)
            border = 1'b1;
        if (height >= 12'd5 && row >= height - 12'd2)
            border = 1'b1;
    end

    always_comb begin
        pix_next = '0;
        if (d_dv) begin
            if (!border)
                pix_next = {filt_red, filt_green, filt_blue};
            else if (BORDER_MODE == 1)
                pix_next = d_pix;
        end
    end

    // vsync wins over a coincident hsync edge; a blank line (col==0) is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hs <= 1'b0;
            prev_vs <= 1'b0;
            col     <= '0;
            row     <= '0;
            width   <= '0;
            height  <= '0;
        end else begin
            prev_hs <= d_hs;
            prev_vs <= d_vs;
            if (vs_rise) begin
                if (row != 12'd0) height <= row;
                row <= '0;
                col <= '0;
            end else if (hs_rise) begin
                col <= '0;
                if (col != 12'd0) begin
                    width <= col;
                    if (row != 12'hFFF) row <= row + 12'd1;
                end
            end else if (d_dv && col != 12'hFFF) begin
                col <= col + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_dv    <= 1'b0;
            tx_hs    <= 1'b0;
            tx_vs    <= 1'b0;
            tx_red   <= '0;
            tx_green <= '0;
            tx_blue  <= '0;
        end else begin
            tx_dv <= d_dv;
            tx_hs <= d_hs;
            tx_vs <= d_vs;
            {tx_red, tx_green, tx_blue} <= pix_next;
        end
    end
endmodule

// File: tb/tb_hdmi_tx_align.sv
// Randomized bench for hdmi_tx_align: both border modes driven from one stream and
// compared every cycle against a cycle-indexed behavioural model of the video rules.
module tb_hdmi_tx_align;
    localparam int L = 8;
    localparam int W = 51;

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_hs = 1'b0;
    logic        rx_vs = 1'b0;
    logic [23:0] center_pixel = '0;
    logic [7:0]  filt_red = '0;
    logic [7:0]  filt_green = '0;
    logic [7:0]  filt_blue = '0;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        dv0, hs0, vs0, dv1, hs1, vs1;
    logic [11:0] w0, h0, w1, h1;

    always #5 clk = ~clk;

    hdmi_tx_align #(.LATENCY(L), .BORDER_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .center_pixel(center_pixel), .filt_red(filt_red), .filt_green(filt_green),
        .filt_blue(filt_blue), .tx_red(r0), .tx_green(g0), .tx_blue(b0),
        .tx_dv(dv0), .tx_hs(hs0), .tx_vs(vs0), .width(w0), .height(h0)
    );

    hdmi_tx_align #(.LATENCY(L), .BORDER_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .center_pixel(center_pixel), .filt_red(filt_red), .filt_green(filt_green),
        .filt_blue(filt_blue), .tx_red(r1), .tx_green(g1), .tx_blue(b1),
        .tx_dv(dv1), .tx_hs(hs1), .tx_vs(vs1), .width(w1), .height(h1)
    );

    typedef struct {
        logic        dv;
        logic        hs;
        logic        vs;
        logic        rst;
        logic [23:0] center;
        logic [23:0] filt;
    } rec_t;

    rec_t        hist[$];
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    int checks = 0;
    int failures = 0;

    int   m_col = 0, m_row = 0, m_width = 0, m_height = 0;
    logic m_phs = 1'b0, m_pvs = 1'b0;
    int   last_rst = -1000;

    logic        use_fix = 1'b0;
    logic [23:0] fix_center = '0;
    logic        use_force = 1'b0;
    logic [23:0] force_filt = '0;
    int          mark_cycle = -1;
    int          rst_mark = -1000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected result of clock edge p, built from the video rules on plain integers.
    task automatic model_posedge(input int p);
        rec_t        d;
        logic        brd;
        logic        hs_edge, vs_edge;
        logic [23:0] pix0, pix1;
        if (hist[p].rst) begin
            m_col = 0; m_row = 0; m_width = 0; m_height = 0;
            m_phs = 1'b0; m_pvs = 1'b0;
            last_rst = p;
            exp0_q.push_back('0);
            exp1_q.push_back('0);
            return;
        end
        if (p < L || last_rst >= p - L)
            d = '{dv: 1'b0, hs: 1'b0, vs: 1'b0, rst: 1'b0, center: 24'h0, filt: 24'h0};
        else
            d = hist[p-L];
        brd = (m_col < 2) || (m_row < 2) ||
              (m_width >= 5 && m_col >= m_width - 2) ||
              (m_height >= 5 && m_row >= m_height - 2);
        pix0 = '0;
        pix1 = '0;
        if (d.dv) begin
            pix0 = brd ? 24'h0 : d.filt;
            pix1 = brd ? d.center : d.filt;
        end
        hs_edge = d.hs && !m_phs;
        vs_edge = d.vs && !m_pvs;
        m_phs = d.hs;
        m_pvs = d.vs;
        if (vs_edge) begin
            if (m_row > 0) m_height = m_row;
            m_row = 0;
            m_col = 0;
        end else if (hs_edge) begin
            if (m_col > 0) begin
                m_width = m_col;
                m_row = (m_row < 4095) ? m_row + 1 : 4095;
            end
            m_col = 0;
        end else if (d.dv) begin
            m_col = (m_col < 4095) ? m_col + 1 : 4095;
        end
        exp0_q.push_back({12'(m_width), 12'(m_height), d.dv, d.hs, d.vs, pix0});
        exp1_q.push_back({12'(m_width), 12'(m_height), d.dv, d.hs, d.vs, pix1});
    endtask

    task automatic compare(input int p);
        logic [W-1:0] e0, e1;
        if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
            check("exp_underflow", 64'd1, 64'd0);
            return;
        end
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        check("dut0_out", {w0, h0, dv0, hs0, vs0, r0, g0, b0}, e0);
        check("dut1_out", {w1, h1, dv1, hs1, vs1, r1, g1, b1}, e1);
        if (mark_cycle >= 0 && p - L == mark_cycle) begin
            check("lat9_dv", dv0, 1'b1);
            check("lat9_rgb0", {r0, g0, b0}, 24'hAABBCC);
            check("lat9_rgb1", {r1, g1, b1}, 24'hAABBCC);
        end
        if (p >= rst_mark && p <= rst_mark + L)
            check("rst_quiet_dv", {dv0, dv1}, 2'b00);
    endtask

    task automatic step(input logic dv, input logic hs, input logic vs,
                        input logic [23:0] center, input logic r);
        rec_t rc;
        int   c;
        @(negedge clk);
        c = hist.size();
        if (c > 0) compare(c - 1);
        rc.dv = dv;
        rc.hs = hs;
        rc.vs = vs;
        rc.rst = r;
        rc.center = use_fix ? fix_center : center;
        rc.filt = use_force ? force_filt : 24'($urandom);
        hist.push_back(rc);
        rst = r;
        rx_dv = dv;
        rx_hs = hs;
        rx_vs = vs;
        center_pixel = rc.center;
        if (c >= L)
            {filt_red, filt_green, filt_blue} = hist[c-L].filt;
        else
            {filt_red, filt_green, filt_blue} = 24'($urandom);
        model_posedge(c);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    endtask

    task automatic hsync();
        idle(1 + int'($urandom_range(0, 1)));
        repeat (1 + int'($urandom_range(0, 1))) step(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
        idle(1);
    endtask

    task automatic vsync(input logic with_hs);
        idle(1);
        repeat (1 + int'($urandom_range(0, 1))) step(1'b0, with_hs, 1'b1, 24'($urandom), 1'b0);
        idle(1);
    endtask

    task automatic pixels(input int n, input logic holes, input int special);
        for (int i = 0; i < n; i++) begin
            if (holes && $urandom_range(0, 7) == 0) idle(1);
            if (i == special) begin
                use_force = 1'b1;
                force_filt = 24'hAABBCC;
                mark_cycle = hist.size();
                step(1'b1, 1'b0, 1'b0, 24'h123456, 1'b0);
                use_force = 1'b0;
            end else begin
                step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
            end
        end
    endtask

    task automatic frame(input int w, input int h, input logic holes,
                         input int sp_row, input int sp_col);
        for (int r = 0; r < h; r++) begin
            if ($urandom_range(0, 5) == 0) hsync();
            pixels(w, holes, (r == sp_row) ? sp_col : -1);
            hsync();
        end
        vsync(1'($urandom_range(0, 1)));
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        idle(1);
        check("reset_size", {w0, h0, w1, h1}, 48'h0);
        check("reset_tx", {dv0, hs0, vs0, r0, g0, b0}, 27'h0);

        // 16x16 frames: first without measured height, second with fixed centre colour.
        vsync(1'b0);
        frame(16, 16, 1'b0, 3, 4);
        idle(L + 3);
        check("frame_a_size", {w0, h0}, {12'd16, 12'd16});
        use_fix = 1'b1;
        fix_center = 24'h102030;
        frame(16, 16, 1'b0, -1, -1);
        use_fix = 1'b0;

        for (int f = 0; f < 3; f++)
            frame(int'($urandom_range(5, 20)), int'($urandom_range(3, 12)), 1'b1, -1, -1);

        // Wide lines: width after the first hsync, unaffected by blank lines.
        pixels(640, 1'b1, -1);
        hsync();
        idle(L + 3);
        check("width_640", w0, 12'd640);
        hsync();
        pixels(640, 1'b1, -1);
        hsync();
        pixels(640, 1'b0, -1);
        hsync();
        hsync();
        vsync(1'b0);
        idle(L + 3);
        check("height_3", {w0, h0}, {12'd640, 12'd3});

        // Tall frame: 480 short lines with occasional blank lines.
        for (int r = 0; r < 480; r++) begin
            if ($urandom_range(0, 15) == 0) hsync();
            pixels(6, 1'b0, -1);
            hsync();
        end
        hsync();
        vsync(1'b1);
        idle(L + 3);
        check("height_480", {w0, h0}, {12'd6, 12'd480});

        // vsync in the middle of row 7.
        for (int r = 0; r < 7; r++) begin
            pixels(16, 1'b0, -1);
            hsync();
        end
        pixels(100, 1'b0, -1);
        vsync(1'b0);
        pixels(16, 1'b0, -1);
        hsync();
        check("height_7", h0, 12'd7);
        frame(16, 16, 1'b1, -1, -1);

        // One-clock reset in the middle of a line.
        pixels(10, 1'b0, -1);
        rst_mark = hist.size();
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b1);
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
        check("midrst_size", {w0, h0, w1, h1}, 48'h0);
        check("midrst_tx", {dv0, r0, g0, b0, dv1, r1, g1, b1}, 50'h0);
        pixels(10, 1'b0, -1);
        hsync();
        frame(16, 16, 1'b0, -1, -1);
        frame(16, 16, 1'b1, -1, -1);
        idle(L + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
